// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared state encoding and constants for the MIPS fetch controller.
package mips_fetch_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, REFILL = 2'd1, RESTART = 2'd2} fetch_state_t;
    localparam int unsigned PC_INCREMENT = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/mips_refill_sequencer.sv
// mips_refill_sequencer: line refill handshake to instruction memory (request, beat counting, done).
module mips_refill_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    localparam int BEAT_W = $clog2(LINE_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  ack,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  fill_write,
    output logic [BEAT_W-1:0]     beat_count,
    output logic                  done
);
    // mem_req is high exactly while the controller sits in REFILL
    assign fill_write = mem_req && ack && !rst;
    assign done = fill_write && beat_count == BEAT_W'(LINE_WORDS - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            beat_count <= '0;
        end else if (start) begin
            mem_req    <= 1'b1;
            mem_addr   <= {miss_addr[ADDR_WIDTH-1:BEAT_W+2], (BEAT_W + 2)'(0)};
            beat_count <= '0;
        end else if (fill_write) begin
            beat_count <= done ? '0 : beat_count + 1'b1;
            mem_req    <= !done;
        end
    end
endmodule

// File: rtl/mips_fetch_controller.sv
// mips_fetch_controller: PC advance/hold/redirect control with I-cache miss refill and redirect replay.
module mips_fetch_controller
    import mips_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int LINE_WORDS = 4,
    localparam int BEAT_W = $clog2(LINE_WORDS)
) (
    input  logic                  ClockPulse,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] CurrentInstructionAddress,
    input  logic                  CacheHit,
    input  logic                  HazardStall,
    input  logic                  BranchTaken,
    input  logic [ADDR_WIDTH-1:0] BranchTarget,
    input  logic                  JumpTaken,
    input  logic [ADDR_WIDTH-1:0] JumpTarget,
    output logic [ADDR_WIDTH-1:0] NextInstructionAddress,
    output logic                  PcWriteEnable,
    output logic                  FetchValid,
    output logic                  MemReq,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    input  logic                  MemAck,
    output logic                  FillWrite,
    output logic [BEAT_W-1:0]     FillWordIndex,
    output logic [15:0]           MissCount
);
    fetch_state_t state, next_state;
    logic redir, start, done, redirect_pending;
    logic [ADDR_WIDTH-1:0] redir_addr, redirect_target;
    logic [15:0] miss_count;
    // the branch sits in EX, so it is older than a jump in ID and takes priority
    assign redir = BranchTaken | JumpTaken;
    assign redir_addr = BranchTaken ? BranchTarget : JumpTarget;
    assign MissCount = miss_count;
    always_comb begin
        next_state = state;
        NextInstructionAddress = CurrentInstructionAddress + ADDR_WIDTH'(PC_INCREMENT);
        PcWriteEnable = 1'b0;
        FetchValid = 1'b0;
        start = 1'b0;
        if (Reset) begin
            NextInstructionAddress = RESET_VECTOR;
            PcWriteEnable = 1'b1;
            next_state = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (redir) begin
                        NextInstructionAddress = redir_addr;
                        PcWriteEnable = 1'b1;
                    end else if (CacheHit) begin
                        FetchValid = 1'b1;
                        PcWriteEnable = !HazardStall;
                    end else begin
                        start = 1'b1;
                        next_state = REFILL;
                    end
                end
                REFILL: next_state = done ? RESTART : REFILL;
                RESTART: begin
                    NextInstructionAddress = redir ? redir_addr : redirect_target;
                    PcWriteEnable = redir || redirect_pending;
                    next_state = RUN;
                end
                default: next_state = RUN;
            endcase
        end
    end
    always_ff @(posedge ClockPulse) begin
        if (Reset) begin
            state <= RUN;
            redirect_pending <= 1'b0;
            redirect_target <= '0;
            miss_count <= '0;
        end else begin
            state <= next_state;
            if (state == REFILL && redir) begin
                redirect_pending <= 1'b1;
                redirect_target <= redir_addr;
            end else if (state == RESTART) begin
                redirect_pending <= 1'b0;
            end
            if (start && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end
    mips_refill_sequencer #(.ADDR_WIDTH(ADDR_WIDTH), .LINE_WORDS(LINE_WORDS)) u_refill (
        .clk(ClockPulse),
        .rst(Reset),
        .start(start),
        .miss_addr(CurrentInstructionAddress),
        .ack(MemAck),
        .mem_req(MemReq),
        .mem_addr(MemAddr),
        .fill_write(FillWrite),
        .beat_count(FillWordIndex),
        .done(done)
    );
endmodule

// File: tb/tb_mips_fetch_controller.sv
// tb_mips_fetch_controller: directed vectors and hand-written refill sequences for the fetch controller.
module tb_mips_fetch_controller;
    logic clk = 1'b0;
    logic rst, hit, stall, br, jmp, ack, track;
    logic [31:0] brt, jt, pc_reg, pc_set, cur_pc, nxt, maddr;
    logic we, fv, mreq, fw;
    logic [1:0] idx;
    logic [15:0] mc;
    int n_tests = 0;
    int n_fail = 0;

    // bench-side PC register; table vectors drive the PC directly instead
    assign cur_pc = track ? pc_reg : pc_set;
    always #5 clk = ~clk;
    always @(posedge clk) if (we) pc_reg <= nxt;

    mips_fetch_controller dut (
        .ClockPulse(clk), .Reset(rst), .CurrentInstructionAddress(cur_pc),
        .CacheHit(hit), .HazardStall(stall), .BranchTaken(br), .BranchTarget(brt),
        .JumpTaken(jmp), .JumpTarget(jt), .NextInstructionAddress(nxt),
        .PcWriteEnable(we), .FetchValid(fv), .MemReq(mreq), .MemAddr(maddr),
        .MemAck(ack), .FillWrite(fw), .FillWordIndex(idx), .MissCount(mc)
    );

    typedef struct {
        logic [31:0] pc;
        logic hit, stall, br, jmp, ack;
        logic [31:0] brt, jt;
        logic we, fv;
        logic [31:0] nxt;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{32'h40, 1, 0, 0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h44};
        vecs[1] = '{32'h40, 1, 1, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h44};
        vecs[2] = '{32'h10, 1, 0, 0, 1, 0, 32'h0, 32'h90, 1, 0, 32'h90};
        vecs[3] = '{32'h20, 0, 1, 1, 1, 0, 32'h80, 32'h90, 1, 0, 32'h80};
        vecs[4] = '{32'hFFFF_FFFC, 1, 0, 0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h0};
        vecs[5] = '{32'h50, 0, 1, 1, 0, 1, 32'hABC0, 32'h0, 1, 0, 32'hABC0};
        vecs[6] = '{32'h60, 1, 0, 0, 0, 1, 32'h0, 32'h0, 1, 1, 32'h64};

        rst = 1; hit = 1; stall = 0; br = 0; jmp = 0; ack = 0; track = 1;
        brt = 0; jt = 0; pc_set = 0;
        // reset: PC forced to the reset vector
        @(negedge clk); #1;
        chk("rst_we", 32'(we), 1);
        chk("rst_next", nxt, 0);
        chk("rst_memreq", 32'(mreq), 0);
        chk("rst_misscount", 32'(mc), 0);
        @(negedge clk);
        rst = 0; #1;
        chk("run_pc0", pc_reg, 0);
        chk("run_fv", 32'(fv), 1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("run_pc_seq", pc_reg, 32'(4 * i));
        end
        jmp = 1; jt = 32'h40;
        @(negedge clk);
        jmp = 0;
        chk("jump_pc", pc_reg, 32'h40);

        // miss at 0x40 and full line refill
        hit = 0; #1;
        chk("miss_we", 32'(we), 0);
        chk("miss_fv", 32'(fv), 0);
        @(negedge clk);
        hit = 1; stall = 1;
        chk("refill_memreq", 32'(mreq), 1);
        chk("refill_memaddr", maddr, 32'h40);
        chk("refill_misscount", 32'(mc), 1);
        for (int b = 0; b < 4; b++) begin
            ack = 1; #1;
            chk("beat_fillwrite", 32'(fw), 1);
            chk("beat_index", 32'(idx), 32'(b));
            chk("beat_we", 32'(we), 0);
            @(negedge clk);
            chk("beat_pc_hold", pc_reg, 32'h40);
            chk("beat_memreq", 32'(mreq), (b < 3) ? 32'd1 : 32'd0);
        end
        ack = 0; stall = 0; #1;
        chk("restart_we", 32'(we), 0);
        @(negedge clk); #1;
        chk("resume_we", 32'(we), 1);
        chk("resume_next", nxt, 32'h44);
        @(negedge clk);
        chk("resume_pc", pc_reg, 32'h44);

        // redirects captured during refill; the later branch wins
        hit = 0;
        @(negedge clk);
        hit = 1;
        chk("align_memaddr", maddr, 32'h40);
        chk("misscount2", 32'(mc), 2);
        ack = 1; jmp = 1; jt = 32'h100; #1;
        chk("refill_redir_we", 32'(we), 0);
        @(negedge clk);
        ack = 0; jmp = 0;
        @(negedge clk);
        ack = 1; br = 1; brt = 32'h200;
        @(negedge clk);
        br = 0;
        @(negedge clk);
        @(negedge clk);
        ack = 0; #1;
        chk("replay_we", 32'(we), 1);
        chk("replay_next", nxt, 32'h200);
        @(negedge clk);
        chk("replay_pc", pc_reg, 32'h200);

        // reset in the middle of a refill
        hit = 0;
        @(negedge clk);
        hit = 1; ack = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 1; #1;
        chk("rst_refill_fillwrite", 32'(fw), 0);
        chk("rst_refill_we", 32'(we), 1);
        chk("rst_refill_next", nxt, 0);
        @(negedge clk);
        rst = 0; #1;
        chk("post_rst_memreq", 32'(mreq), 0);
        chk("stray_ack_fillwrite", 32'(fw), 0);
        chk("post_rst_misscount", 32'(mc), 0);
        chk("post_rst_pc", pc_reg, 0);
        chk("post_rst_fv", 32'(fv), 1);
        ack = 0;

        // directed RUN-state vectors
        track = 0;
        for (int i = 0; i < 7; i++) begin
            pc_set = vecs[i].pc; hit = vecs[i].hit; stall = vecs[i].stall;
            br = vecs[i].br; jmp = vecs[i].jmp; ack = vecs[i].ack;
            brt = vecs[i].brt; jt = vecs[i].jt; #1;
            chk($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].we));
            chk($sformatf("vec%0d_next", i), nxt, vecs[i].nxt);
            chk($sformatf("vec%0d_fv", i), 32'(fv), 32'(vecs[i].fv));
            chk($sformatf("vec%0d_fillwrite", i), 32'(fw), 0);
            @(negedge clk);
            chk($sformatf("vec%0d_no_memreq", i), 32'(mreq), 0);
        end
        br = 0; jmp = 0; ack = 0; stall = 0; hit = 1;

        // miss counter saturation
        pc_set = 32'h300;
        force dut.miss_count = 16'hFFFF;
        #1;
        release dut.miss_count;
        chk("sat_preload", 32'(mc), 32'hFFFF);
        hit = 0;
        @(negedge clk);
        hit = 1;
        chk("sat_misscount", 32'(mc), 32'hFFFF);
        chk("sat_memreq", 32'(mreq), 1);
        chk("sat_memaddr", maddr, 32'h300);
        ack = 1;
        repeat (4) @(negedge clk);
        ack = 0;
        chk("sat_done_memreq", 32'(mreq), 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_fetch_controller.md
Name: mips_fetch_controller

Overview:
Sequences the MIPS program counter register and the instruction-cache refill path.
- Each cycle, decides whether the PC advances, holds or is redirected. It drives the PC register's NextInstructionAddress and its write-enable, which connects to the PC's hit input.
- On an I-cache miss, freezes the PC and runs a line refill handshake to instruction memory.
- Captures branch/jump redirects that arrive during a refill and replays them afterwards.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory addresses.
- RESET_VECTOR, 32'h0000_0000, PC value forced while Reset is high.
- LINE_WORDS, 4, 32-bit words per cache line. Must be a power of 2, ≥2. BEAT_W = log2(LINE_WORDS).

Ports:
- ClockPulse  in  1  system clock; controller state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- CurrentInstructionAddress  in  ADDR_WIDTH  present PC value.
- CacheHit  in  1  I-cache tag match for CurrentInstructionAddress.
- HazardStall  in  1  pipeline hazard unit requests a PC hold.
- BranchTaken  in  1  branch resolved taken this cycle (EX stage).
- BranchTarget  in  ADDR_WIDTH  branch target address.
- JumpTaken  in  1  jump decoded this cycle (ID stage).
- JumpTarget  in  ADDR_WIDTH  jump target address.
- NextInstructionAddress  out  ADDR_WIDTH  to PC register (combinational).
- PcWriteEnable  out  1  to PC register hit input (combinational).
- FetchValid  out  1  instruction word on the fetch bus is valid this cycle.
- MemReq  out  1  refill request (registered).
- MemAddr  out  ADDR_WIDTH  line-aligned refill address (registered).
- MemAck  in  1  one data beat delivered this cycle.
- FillWrite  out  1  write the current beat into the cache (= state==REFILL && MemAck).
- FillWordIndex  out  BEAT_W  word index of the current beat (= BeatCount).
- MissCount  out  16  saturating count of misses started.

Behaviour:
- States: RUN, REFILL, RESTART. Internal registers:
  - MissAddr
  - BeatCount (BEAT_W bits)
  - RedirectPending
  - RedirectTarget
- Redirect selection (Redir, RedirAddr): BranchTaken wins over JumpTaken, because the branch is the older instruction. Redir = BranchTaken | JumpTaken.
- Reset high:
  - State→RUN; MemReq=0, MemAddr=0, BeatCount=0, RedirectPending=0, MissCount=0.
  - PcWriteEnable=1 and NextInstructionAddress=RESET_VECTOR combinationally, because the PC register has no reset of its own.
  - A reset during REFILL abandons the refill: MemReq=0 from the next edge. Any MemAck during reset is ignored.
- RUN:
  - Redir=1: PcWriteEnable=1, Next=RedirAddr, regardless of HazardStall or CacheHit. A miss on the squashed fetch does not start a refill; state stays RUN.
  - Else CacheHit=1: FetchValid=1, PcWriteEnable=!HazardStall, Next=PC+4 (modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC wraps to 0).
  - Else (miss): PcWriteEnable=0, FetchValid=0. On the edge: state→REFILL, MemAddr=PC with the low BEAT_W+2 bits cleared, MemReq=1, BeatCount=0, MissCount+1 (saturating at 16'hFFFF).
- REFILL:
  - PcWriteEnable=0, FetchValid=0, MemReq held at 1.
  - Each MemAck: FillWrite=1, BeatCount+1.
  - MemAck with BeatCount==LINE_WORDS-1: on the edge, MemReq=0, BeatCount=0, state→RESTART.
  - Redir in REFILL: RedirectPending=1, RedirectTarget=RedirAddr. A later redirect overwrites an earlier one.
  - HazardStall has no effect.
- RESTART (exactly 1 cycle, for cache tag settle):
  - Live Redir: PcWriteEnable=1, Next=RedirAddr.
  - Else RedirectPending: PcWriteEnable=1, Next=RedirectTarget.
  - Else PcWriteEnable=0.
  - RedirectPending clears on the edge; state→RUN.
- Miss-to-resume latency: 1 (request) + LINE_WORDS acked beats + 1 (RESTART). The refetch happens in RUN.
- MemAck outside REFILL: ignored; FillWrite=0.

Decomposition:
- Package mips_fetch_pkg holds:
  - the state encoding (RUN=2'd0, REFILL=2'd1, RESTART=2'd2)
  - PC_INCREMENT=4
  - the default RESET_VECTOR
- One sub-module, mips_refill_sequencer, contains the MemReq/MemAddr/BeatCount/FillWrite handshake with start/done signals.
- The top level contains the FSM, the redirect mux, the pending-redirect capture and MissCount.

Test Plan:
1. Reset for 2 cycles, then release with CacheHit=1 and no stall → PcWriteEnable=1 during reset with Next=0. After release the PC goes 0, 4, 8, 12 on successive cycles.
2. PC=0x40, CacheHit=0 → next cycle MemReq=1, MemAddr=0x40. Four MemAck beats → FillWordIndex 0,1,2,3 with FillWrite=1 on each, then RESTART. MissCount=1. PC holds at 0x40 throughout. After RESTART the PC resumes at 0x44.
3. During REFILL, pulse JumpTaken with target 0x100, then BranchTaken with target 0x200 → in RESTART, PcWriteEnable=1 and Next=0x200.
4. In RUN, BranchTaken=1, JumpTaken=1 (targets 0x80 / 0x90), HazardStall=1 and CacheHit=0 on the same cycle → Next=0x80, PcWriteEnable=1, no MemReq.
5. Assert Reset at beat 2 of a refill → MemReq=0 after the edge and state returns to RUN. A stray MemAck gives FillWrite=0. The PC is forced to RESET_VECTOR.
6. PC=32'hFFFF_FFFC with a hit → Next=0. Also force MissCount to 16'hFFFF, trigger a miss, and check it stays at 16'hFFFF.
